vdp_sprite_hit_scan: RTL

Per-line sprite scanner. It sits directly upstream of the sprite renderer. On each line start it walks the 256-entry sprite y_block attribute table and writes one hit-list entry for every sprite that intersects the requested line: `{sprite_id, line_offset, width_select}`. The list is closed with an end marker. The renderer then consumes the hit list from address 0 and stops at the end marker, or at read address bit 8 when the list is full.

---
 rtl/vdp_sprite_pkg.sv | 43 ++++
 rtl/vdp_sprite_hit_test.sv | 32 +++
 rtl/vdp_sprite_hit_scan.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vdp_sprite_pkg.sv
// Shared sprite constants and hit-list entry layout, used by the hit scanner
// and the sprite renderer.
package vdp_sprite_pkg;

  localparam int SPRITE_COUNT  = 256;
  localparam int SPRITE_ID_W   = 8;
  localparam int LINE_OFFSET_W = 4;
  localparam int ENTRY_W       = 14;

  // Entry layout: {sprite_id[7:0], line_offset[3:0], width_select, ended}
  localparam int ENDED_BIT  = 0;
  localparam int WIDTH_BIT  = 1;
  localparam int OFFSET_LSB = 2;
  localparam int ID_LSB     = 6;

  localparam int HEIGHT_SMALL = 8;
  localparam int HEIGHT_LARGE = 16;
  localparam int WIDTH_SMALL  = 8;
  localparam int WIDTH_LARGE  = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SCAN      = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_TERMINATE = 2'd3
  } scan_state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [SPRITE_ID_W-1:0]   sprite_id,
    input logic [LINE_OFFSET_W-1:0] line_offset,
    input logic                     width_select,
    input logic                     ended
  );
    logic [ENTRY_W-1:0] entry;
    entry = '0;
    entry[ID_LSB +: SPRITE_ID_W]       = sprite_id;
    entry[OFFSET_LSB +: LINE_OFFSET_W] = line_offset;
    entry[WIDTH_BIT]                   = width_select;
    entry[ENDED_BIT]                   = ended;
    return entry;
  endfunction

endpackage

// File: rtl/vdp_sprite_hit_test.sv
// Combinational vertical hit test and line offset (with optional y flip) for
// one sprite against the current line.
module vdp_sprite_hit_test
  import vdp_sprite_pkg::*;
(
  input  logic [8:0] line_y_i,
  input  logic [8:0] sprite_y_i,
  input  logic       height_select_i,
  input  logic       flip_y_i,
  output logic       hit_o,
  output logic [3:0] line_offset_o
);

  logic [8:0] diff;
  logic [8:0] height;

  always_comb begin
    // Modulo-512 difference lets sprites straddle the 511 -> 0 boundary.
    diff          = line_y_i - sprite_y_i;
    height        = height_select_i ? 9'(HEIGHT_LARGE) : 9'(HEIGHT_SMALL);
    hit_o         = (diff < height);
    line_offset_o = diff[3:0];
    if (flip_y_i) begin
      if (height_select_i) begin
        line_offset_o = 4'd15 - diff[3:0];
      end else begin
        line_offset_o = {1'b0, 3'd7 - diff[2:0]};
      end
    end
  end

endmodule

// File: rtl/vdp_sprite_hit_scan.sv
// Per-line sprite scanner: walks the y_block table and writes the hit list plus
// end marker. Optional pixel budget limit: VDP_SPRITE_PIXEL_BUDGET_EN.
module vdp_sprite_hit_scan
  import vdp_sprite_pkg::*;
#(
  parameter int MAX_HITS     = 256,
  parameter int PIXEL_BUDGET = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [8:0]  line_y,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [8:0]  hit_count,
  output logic [7:0]  y_block_address,
  input  logic [8:0]  sprite_y,
  input  logic        height_select,
  input  logic        width_select,
  input  logic        flip_y,
  output logic [7:0]  hit_list_write_address,
  output logic [13:0] hit_list_write_data,
  output logic        hit_list_write_en
);

  localparam logic [8:0] MAX_HITS_C = 9'(MAX_HITS);

  // Empty marker block: only reachable with parameters outside the legal range.
  if (PIXEL_BUDGET > 1023 || MAX_HITS < 1 || MAX_HITS > SPRITE_COUNT) begin : g_param_out_of_range
  end

  scan_state_e        state_q, state_d;
  logic [7:0]         addr_q, addr_d;
  logic               drain_q, drain_d;
  logic [8:0]         line_y_q, line_y_d;
  logic               s1_valid_q, s1_valid_d;
  logic [7:0]         s1_id_q, s1_id_d;
  logic [8:0]         hit_count_q, hit_count_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               wr_en_q, wr_en_d;
  logic [7:0]         wr_addr_q, wr_addr_d;
  logic [ENTRY_W-1:0] wr_data_q, wr_data_d;

  logic       hit;
  logic [3:0] line_offset;
  logic       room_ok;
  logic       budget_ok;
  logic       accept;
  logic       drop;

  vdp_sprite_hit_test u_hit_test (
    .line_y_i        (line_y_q),
    .sprite_y_i      (sprite_y),
    .height_select_i (height_select),
    .flip_y_i        (flip_y),
    .hit_o           (hit),
    .line_offset_o   (line_offset)
  );

  assign room_ok = (hit_count_q < MAX_HITS_C);
  assign accept  = s1_valid_q & hit & room_ok & budget_ok;
  assign drop    = s1_valid_q & hit & ~(room_ok & budget_ok);

`ifdef VDP_SPRITE_PIXEL_BUDGET_EN
  localparam logic [10:0] BUDGET_C = 11'(PIXEL_BUDGET);

  logic [9:0]  pix_acc_q, pix_acc_d;
  logic [10:0] pix_sum;

  always_comb begin
    pix_sum   = {1'b0, pix_acc_q} + (width_select ? 11'(WIDTH_LARGE) : 11'(WIDTH_SMALL));
    budget_ok = (pix_sum <= BUDGET_C);
    pix_acc_d = pix_acc_q;
    if (start) begin
      pix_acc_d = '0;
    end else if (accept) begin
      pix_acc_d = pix_sum[9:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_acc_q <= '0;
    end else begin
      pix_acc_q <= pix_acc_d;
    end
  end
`else
  assign budget_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = '0;
    drain_d     = 1'b0;
    line_y_d    = line_y_q;
    s1_valid_d  = 1'b0;
    s1_id_d     = addr_q;
    hit_count_d = hit_count_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;

    case (state_q)
      ST_SCAN: begin
        s1_valid_d = 1'b1;
        if (addr_q == 8'hFF) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) begin
          state_d = ST_TERMINATE;
          done_d  = 1'b1;
          // A full 256-entry list has no slot left; address bit 8 ends it.
          if (hit_count_q != 9'd256) begin
            wr_en_d   = 1'b1;
            wr_addr_d = hit_count_q[7:0];
            wr_data_d = pack_entry(8'd0, 4'd0, 1'b0, 1'b1);
          end
        end
      end
      ST_TERMINATE: state_d = ST_IDLE;
      default: ;
    endcase

    if (accept) begin
      wr_en_d     = 1'b1;
      wr_addr_d   = hit_count_q[7:0];
      wr_data_d   = pack_entry(s1_id_q, line_offset, width_select, 1'b0);
      hit_count_d = hit_count_q + 9'd1;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end

    // A start always wins, including mid-scan: in-flight work is discarded.
    if (start) begin
      state_d     = ST_SCAN;
      addr_d      = '0;
      drain_d     = 1'b0;
      line_y_d    = line_y;
      s1_valid_d  = 1'b0;
      hit_count_d = '0;
      overflow_d  = 1'b0;
      done_d      = 1'b0;
      wr_en_d     = 1'b0;
      wr_addr_d   = '0;
      wr_data_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      drain_q     <= 1'b0;
      line_y_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      hit_count_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      line_y_q    <= line_y_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      hit_count_q <= hit_count_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy                   = (state_q != ST_IDLE);
  assign done                   = done_q;
  assign overflow               = overflow_q;
  assign hit_count              = hit_count_q;
  assign y_block_address        = addr_q;
  assign hit_list_write_address = wr_addr_q;
  assign hit_list_write_data    = wr_data_q;
  assign hit_list_write_en      = wr_en_q;

endmodule
